i2c_slave_regs: RTL and testbench
=================================

Name: i2c_slave_regs

Overview:
- I2C target (responder) for the team's I2C master write tasks; the bench drives the bus, and this block answers it.
- Holds a small byte-wide register file, with a device address, a register pointer, auto-increment, reads and writes.
- Samples SCL/SDA with the 50 MHz system clock and drives SDA open-drain via an output-enable only.
- Also exposes a host-side read port and a write strobe for downstream logic.

Parameters:
DEV_ADDR, 7'h50, 7-bit I2C device address matched after START.
ADDR_W, 4, register index width; register file depth is 2**ADDR_W bytes.

Ports:
clk_50M  input  1  system clock, 50 MHz.
rst_n  input  1  asynchronous active-low reset.
scl_i  input  1  SCL line, asynchronous to clk_50M.
sda_i  input  1  SDA line, asynchronous to clk_50M.
sda_oe  output  1  1 = pull SDA low; 0 = release the line.
wr_stb  output  1  one-cycle pulse when a data byte is committed.
wr_addr  output  ADDR_W  register index of the committed byte.
wr_data  output  8  committed byte.
host_addr  input  ADDR_W  host read index.
host_rdata  output  8  combinational read of the register at host_addr.
busy  output  1  high from an addressed START until STOP or NACK return.

Behaviour:
- Reset values: sda_oe=0, wr_stb=0, wr_addr=0, wr_data=0, busy=0, all registers 8'h00, pointer 0, FSM IDLE.
- Input sync and edge detect: SCL and SDA each pass a 2-FF synchroniser, then an edge detector.
- START = SDA fall while SCL=1. STOP = SDA rise while SCL=1.
- Bus timing: SDA is sampled on SCL rise. sda_oe changes only on a synchronised SCL fall.
- States: IDLE, DEV, ACK_DEV, PTR, ACK_PTR, WDATA, ACK_W, RDATA, RACK.
- START from any state, including a repeated start: go to DEV, clear the bit counter.
- STOP from any state: go to IDLE, sda_oe=0, busy=0.
- DEV: shift 8 bits, MSB first.
  - Upper 7 bits == DEV_ADDR: go to ACK_DEV, busy=1.
  - Mismatch: go to IDLE with no ACK.
- ACK_DEV: sda_oe=1 from the SCL fall after bit 8 until the next SCL fall.
  - R/W=0: go to PTR.
  - R/W=1: load reg[pointer], then RDATA.
- PTR: 8 bits; pointer = lower ADDR_W bits. Then ACK_PTR (ACK as above), then WDATA.
- WDATA: 8 bits, then ACK_W.
  - At the 8th SCL rise, write reg[pointer] and pulse wr_stb with wr_addr=pointer and wr_data=byte.
  - At the same time, pointer increments modulo 2**ADDR_W (15 wraps to 0). Then back to WDATA.
- RDATA: on each SCL fall, sda_oe = ~current bit, MSB first.
  - After the 8th bit's SCL fall, release SDA and go to RACK.
- RACK: sample master ACK on SCL rise.
  - ACK (0): pointer++, load the next byte, then RDATA.
  - NACK (1): IDLE, sda_oe=0, keep the pointer.
- Latency: wr_stb occurs 3 clk_50M cycles after the raw SCL rise (2 sync + 1 register).
- Reset mid-transfer forces all reset values immediately.
- Simultaneous host read and bus write to the same index: host_rdata shows the new value in the cycle after wr_stb.

Optional Feature:
- Macro: I2C_SPIKE_FILTER_EN.
- When defined: after sync, a 3-sample majority filter on SCL and SDA suppresses single-cycle glitches, and line latency grows by 2 cycles. wr_stb then occurs 5 cycles after the SCL rise.
- When undefined: no filter; a 1-cycle glitch on SCL is treated as a real edge.

Decomposition:
- Package i2c_pkg: FSM state enum, ACK=1'b0/NACK=1'b1 constants, default DEV_ADDR constant.
- Sub-module i2c_line_sync: one per line, holding the 2-FF sync, the optional filter, and rise/fall outputs. Instantiated twice (SCL, SDA).

Test Plan:
- Write 0/1/2: Wr_1Byte(8'd0,8'd0), Wr_1Byte(8'd1,8'd1), Wr_1Byte(8'd2,8'd2) -> three wr_stb pulses with (addr,data)=(0,0),(1,1),(2,2); ACK on every byte; host_rdata at index 2 == 8'h02.
- Auto-increment wrap: write at pointer 15 with data A5,5A -> reg[15]=A5, reg[0]=5A, second wr_addr=0.
- Address mismatch: device 7'h51 -> sda_oe stays 0 for the whole transfer, no wr_stb, busy=0.
- Read with repeated start: set pointer 1, repeated start, read 2 bytes with ACK then NACK -> SDA returns 01 then 02; FSM reaches IDLE after NACK.
- Reset mid-byte: assert rst_n=0 after 4 data bits -> sda_oe=0, busy=0, FSM IDLE; the next full write succeeds.
- I2C_SPIKE_FILTER_EN: inject a 1-cycle SCL high glitch during WDATA -> defined: byte unaffected; undefined: the bench records the bit-count corruption as expected behaviour.

Source files
------------

// File: rtl/i2c_slave_regs_pkg.sv
// Shared types and constants for the I2C register target.
// The optional SCL/SDA glitch filter is enabled with I2C_SPIKE_FILTER_EN.
package i2c_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_DEV,
    S_ACK_DEV,
    S_PTR,
    S_ACK_PTR,
    S_WDATA,
    S_ACK_W,
    S_RDATA,
    S_RACK
  } i2c_state_e;

  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;
  localparam logic [6:0] I2C_DEV_ADDR_DEF = 7'h50;

  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/i2c_slave_regs_line_sync.sv
// One bus line: 2-FF synchroniser, optional 3-sample majority filter
// (I2C_SPIKE_FILTER_EN), and registered-history rise/fall detection.
module i2c_line_sync
  import i2c_pkg::*;
(
  input  logic clk_50M,
  input  logic rst_n,
  input  logic i_line,
  output logic o_lvl,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1, r_s2, r_prev, w_lvl;

  // Idle bus is high, so the sync chain resets high to avoid a false edge.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_line;
      r_s2 <= r_s1;
    end
  end

`ifdef I2C_SPIKE_FILTER_EN
  logic [2:0] r_flt;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) r_flt <= 3'b111;
    else        r_flt <= {r_flt[1:0], r_s2};
  end

  assign w_lvl = maj3(r_flt);
`else
  assign w_lvl = r_s2;
`endif

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b1;
    else        r_prev <= w_lvl;
  end

  assign o_lvl  = w_lvl;
  assign o_rise = w_lvl & ~r_prev;
  assign o_fall = ~w_lvl & r_prev;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a byte-wide register file, auto-incrementing pointer and host read port.
// Define I2C_SPIKE_FILTER_EN to add a majority glitch filter on SCL/SDA.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = I2C_DEV_ADDR_DEF,
  parameter int         ADDR_W   = 4
)(
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] host_addr,
  output logic [7:0]        host_rdata,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;

  i2c_line_sync u_scl (
    .clk_50M (clk_50M), .rst_n (rst_n), .i_line (scl_i),
    .o_lvl (w_scl), .o_rise (w_scl_rise), .o_fall (w_scl_fall)
  );

  i2c_line_sync u_sda (
    .clk_50M (clk_50M), .rst_n (rst_n), .i_line (sda_i),
    .o_lvl (w_sda), .o_rise (w_sda_rise), .o_fall (w_sda_fall)
  );

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  i2c_state_e        r_state, w_state_nxt;
  logic [3:0]        r_bitcnt, w_bitcnt_nxt;
  logic [7:0]        r_shift, w_shift_nxt;
  logic [ADDR_W-1:0] r_ptr, w_ptr_nxt, w_ptr_inc;
  logic              r_sda_oe, w_oe_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_wr_stb;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_wr_data;
  logic [7:0]        r_regs [DEPTH];
  logic              w_we;
  logic [7:0]        w_byte, w_rbyte, w_rnext;
  logic              w_last;

  assign w_ptr_inc = r_ptr + ADDR_W'(1);
  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_rbyte   = r_regs[r_ptr];
  assign w_rnext   = r_regs[w_ptr_inc];
  assign w_last    = (r_bitcnt == 4'd7);

  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_oe_nxt     = r_sda_oe;
    w_busy_nxt   = r_busy;
    w_we         = 1'b0;

    if (w_start) begin
      w_state_nxt  = S_DEV;
      w_bitcnt_nxt = 4'd0;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        S_DEV, S_PTR, S_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt  = w_byte;
            w_bitcnt_nxt = r_bitcnt + 4'd1;
            if (w_last) begin
              w_bitcnt_nxt = 4'd0;
              if (r_state == S_DEV) begin
                if (w_byte[7:1] == DEV_ADDR) begin
                  w_state_nxt = S_ACK_DEV;
                  w_busy_nxt  = 1'b1;
                end else begin
                  w_state_nxt = S_IDLE;
                  w_busy_nxt  = 1'b0;
                end
              end else if (r_state == S_PTR) begin
                w_ptr_nxt   = w_byte[ADDR_W-1:0];
                w_state_nxt = S_ACK_PTR;
              end else begin
                w_we        = 1'b1;
                w_ptr_nxt   = w_ptr_inc;
                w_state_nxt = S_ACK_W;
              end
            end
          end
        end

        // First fall after the 8th bit starts the ACK pulse, the next fall ends it.
        S_ACK_DEV, S_ACK_PTR, S_ACK_W: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt     = 1'b0;
              w_bitcnt_nxt = 4'd0;
              if (r_state == S_ACK_DEV && r_shift[0]) begin
                // Read: the fall ending the ACK also presents the first data bit.
                w_oe_nxt     = ~w_rbyte[7];
                w_shift_nxt  = {w_rbyte[6:0], 1'b0};
                w_bitcnt_nxt = 4'd1;
                w_state_nxt  = S_RDATA;
              end else if (r_state == S_ACK_DEV) begin
                w_state_nxt = S_PTR;
              end else begin
                w_state_nxt = S_WDATA;
              end
            end
          end
        end

        S_RDATA: begin
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_RACK;
            end else begin
              w_oe_nxt     = ~r_shift[7];
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_bitcnt_nxt = r_bitcnt + 4'd1;
            end
          end
        end

        S_RACK: begin
          if (w_scl_rise) begin
            if (w_sda == NACK) begin
              w_state_nxt = S_IDLE;
              w_oe_nxt    = 1'b0;
              w_busy_nxt  = 1'b0;
            end else begin
              w_ptr_nxt    = w_ptr_inc;
              w_shift_nxt  = w_rnext;
              w_bitcnt_nxt = 4'd0;
              w_state_nxt  = S_RDATA;
            end
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bitcnt  <= '0;
      r_shift   <= '0;
      r_ptr     <= '0;
      r_sda_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_sda_oe <= w_oe_nxt;
      r_busy   <= w_busy_nxt;
      r_wr_stb <= w_we;
      if (w_we) begin
        r_wr_addr      <= r_ptr;
        r_wr_data      <= w_byte;
        r_regs[r_ptr]  <= w_byte;
      end
    end
  end

  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_stb     = r_wr_stb;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign host_rdata = r_regs[host_addr];

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bit-banged I2C master driving i2c_slave_regs, checked against a byte-array register model.
module tb_i2c_slave_regs;

  localparam logic [6:0] DEV = 7'h50;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       m_scl   = 1'b1;
  logic       m_sda   = 1'b1;
  logic [3:0] host_addr = 4'd0;
  logic       sda_oe, wr_stb, busy;
  logic [3:0] wr_addr;
  logic [7:0] wr_data, host_rdata;
  logic       w_sda;

  assign w_sda = m_sda & ~sda_oe;

  i2c_slave_regs dut (
    .clk_50M (clk_50M), .rst_n (rst_n), .scl_i (m_scl), .sda_i (w_sda),
    .sda_oe (sda_oe), .wr_stb (wr_stb), .wr_addr (wr_addr), .wr_data (wr_data),
    .host_addr (host_addr), .host_rdata (host_rdata), .busy (busy)
  );

  always #10 clk_50M = ~clk_50M;

  int nchk = 0;
  int nerr = 0;

  logic [7:0]  mem [16];
  logic [3:0]  mptr;
  logic [7:0]  tx_q [$];
  logic [7:0]  rx_q [$];
  logic        ack_q [$];
  logic [11:0] exp_q [$];
  logic [11:0] stb_q [$];
  logic        any_oe, any_busy, prev_stb;
  logic [3:0]  prev_addr;
  logic [7:0]  post_rd;
  logic        obs_busy, obs_oe;

  initial begin
    any_oe = 0; any_busy = 0; prev_stb = 0; prev_addr = 0; post_rd = 0;
  end

  always @(negedge clk_50M) begin
    if (wr_stb) stb_q.push_back({wr_addr, wr_data});
    if (sda_oe) any_oe = 1'b1;
    if (busy) any_busy = 1'b1;
    if (prev_stb && prev_addr == host_addr) post_rd = host_rdata;
    prev_stb  = wr_stb;
    prev_addr = wr_addr;
  end

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mptr = 4'd0;
  endtask

  task automatic model_wr(input logic [3:0] p);
    mptr = p;
    foreach (tx_q[i]) begin
      mem[mptr] = tx_q[i];
      exp_q.push_back({mptr, tx_q[i]});
      mptr = mptr + 4'd1;
    end
  endtask

  // ---------------- bus master ----------------
  task automatic hp();
    repeat (10) @(negedge clk_50M);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; m_scl = 1'b1; hp();
    m_sda = 1'b0; hp();
    m_scl = 1'b0;
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; hp();
    bus_start();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; hp();
    m_scl = 1'b1; hp();
    m_sda = 1'b1; hp();
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; hp();
    m_scl = 1'b1; hp();
    m_scl = 1'b0;
  endtask

  // gi >= 0 injects a one-clock SCL high pulse in the low phase of bit gi
  task automatic send_byte(input logic [7:0] b, input int gi, output logic ack);
    for (int i = 0; i < 8; i++) begin
      m_sda = b[7-i];
      if (i == gi) begin
        repeat (5) @(negedge clk_50M);
        m_scl = 1'b1;
        @(negedge clk_50M);
        m_scl = 1'b0;
        repeat (4) @(negedge clk_50M);
      end else begin
        hp();
      end
      m_scl = 1'b1; hp();
      m_scl = 1'b0;
    end
    m_sda = 1'b1; hp();
    m_scl = 1'b1;
    repeat (5) @(negedge clk_50M);
    ack = w_sda;
    repeat (5) @(negedge clk_50M);
    m_scl = 1'b0;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hp();
      m_scl = 1'b1;
      repeat (5) @(negedge clk_50M);
      b[7-i] = w_sda;
      repeat (5) @(negedge clk_50M);
      m_scl = 1'b0;
    end
    send_bit(mack);
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] p);
    logic a;
    bus_start();
    send_byte({dev, 1'b0}, -1, a); ack_q.push_back(a);
    send_byte(p, -1, a);           ack_q.push_back(a);
    foreach (tx_q[i]) begin
      send_byte(tx_q[i], -1, a);   ack_q.push_back(a);
    end
    bus_stop();
  endtask

  task automatic rd_txn(input logic [7:0] p, input int n);
    logic a;
    logic [7:0] b;
    bus_start();
    send_byte({DEV, 1'b0}, -1, a); ack_q.push_back(a);
    send_byte(p, -1, a);           ack_q.push_back(a);
    bus_rstart();
    send_byte({DEV, 1'b1}, -1, a); ack_q.push_back(a);
    for (int k = 0; k < n; k++) begin
      read_byte((k == n - 1) ? 1'b1 : 1'b0, b);
      rx_q.push_back(b);
    end
    repeat (4) @(negedge clk_50M);
    obs_busy = busy;
    obs_oe   = sda_oe;
    bus_stop();
  endtask

  task automatic clear_obs();
    tx_q.delete(); rx_q.delete(); ack_q.delete(); exp_q.delete(); stb_q.delete();
    any_oe = 0; any_busy = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; m_scl = 1'b1; m_sda = 1'b1;
    model_reset();
    repeat (3) @(negedge clk_50M);
    nchk++; if (sda_oe !== 1'b0) begin nerr++; $display("FAIL rst_sda_oe got %b want 0", sda_oe); end
    nchk++; if (wr_stb !== 1'b0) begin nerr++; $display("FAIL rst_wr_stb got %b want 0", wr_stb); end
    nchk++; if (wr_addr !== 4'd0) begin nerr++; $display("FAIL rst_wr_addr got %h want 0", wr_addr); end
    nchk++; if (wr_data !== 8'd0) begin nerr++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b want 0", busy); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      @(negedge clk_50M);
      nchk++; if (host_rdata !== mem[i]) begin nerr++; $display("FAIL rst_reg[%0d] got %h want %h", i, host_rdata, mem[i]); end
    end
    nchk++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rst_idle oe=%b busy=%b want 0 0", sda_oe, busy); end
  endtask

  task automatic test_write012();
    clear_obs();
    host_addr = 4'd2;
    for (int k = 0; k < 3; k++) begin
      tx_q.delete(); tx_q.push_back(8'(k));
      model_wr(4'(k));
      wr_txn(DEV, 8'(k));
    end
    foreach (ack_q[i]) begin
      nchk++; if (ack_q[i] !== 1'b0) begin nerr++; $display("FAIL w012_ack[%0d] got %b want 0", i, ack_q[i]); end
    end
    nchk++;
    if (stb_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL w012_stb_count got %0d want %0d", stb_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      nchk++; if (stb_q[i] !== exp_q[i]) begin nerr++; $display("FAIL w012_stb[%0d] got %h want %h", i, stb_q[i], exp_q[i]); end
    end
    nchk++; if (host_rdata !== 8'h02) begin nerr++; $display("FAIL w012_host_rdata got %h want 02", host_rdata); end
    nchk++; if (post_rd !== 8'h02) begin nerr++; $display("FAIL w012_rdata_after_stb got %h want 02", post_rd); end
    nchk++; if (any_busy !== 1'b1) begin nerr++; $display("FAIL w012_busy_seen got %b want 1", any_busy); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL w012_busy_after_stop got %b want 0", busy); end
  endtask

  task automatic test_wrap();
    clear_obs();
    tx_q.push_back(8'hA5); tx_q.push_back(8'h5A);
    model_wr(4'd15);
    wr_txn(DEV, 8'd15);
    foreach (ack_q[i]) begin
      nchk++; if (ack_q[i] !== 1'b0) begin nerr++; $display("FAIL wrap_ack[%0d] got %b want 0", i, ack_q[i]); end
    end
    nchk++;
    if (stb_q.size() != 2) begin
      nerr++; $display("FAIL wrap_stb_count got %0d want 2", stb_q.size());
    end else begin
      nchk++; if (stb_q[0] !== 12'hFA5) begin nerr++; $display("FAIL wrap_stb0 got %h want fa5", stb_q[0]); end
      nchk++; if (stb_q[1] !== 12'h05A) begin nerr++; $display("FAIL wrap_stb1 got %h want 05a", stb_q[1]); end
    end
    host_addr = 4'd15; @(negedge clk_50M);
    nchk++; if (host_rdata !== mem[15]) begin nerr++; $display("FAIL wrap_reg15 got %h want %h", host_rdata, mem[15]); end
    host_addr = 4'd0; @(negedge clk_50M);
    nchk++; if (host_rdata !== mem[0]) begin nerr++; $display("FAIL wrap_reg0 got %h want %h", host_rdata, mem[0]); end
  endtask

  task automatic test_mismatch();
    logic a;
    clear_obs();
    bus_start();
    send_byte({7'h51, 1'b0}, -1, a);
    nchk++; if (a !== 1'b1) begin nerr++; $display("FAIL mis_addr_ack got %b want 1", a); end
    send_byte(8'h03, -1, a);
    send_byte(8'hAA, -1, a);
    bus_stop();
    nchk++; if (any_oe !== 1'b0) begin nerr++; $display("FAIL mis_sda_oe_seen got %b want 0", any_oe); end
    nchk++; if (stb_q.size() != 0) begin nerr++; $display("FAIL mis_stb_count got %0d want 0", stb_q.size()); end
    nchk++; if (any_busy !== 1'b0) begin nerr++; $display("FAIL mis_busy_seen got %b want 0", any_busy); end
  endtask

  task automatic test_read_rstart();
    clear_obs();
    rd_txn(8'd1, 2);
    foreach (ack_q[i]) begin
      nchk++; if (ack_q[i] !== 1'b0) begin nerr++; $display("FAIL rd_ack[%0d] got %b want 0", i, ack_q[i]); end
    end
    nchk++;
    if (rx_q.size() != 2) begin
      nerr++; $display("FAIL rd_count got %0d want 2", rx_q.size());
    end else begin
      nchk++; if (rx_q[0] !== mem[1]) begin nerr++; $display("FAIL rd_byte0 got %h want %h", rx_q[0], mem[1]); end
      nchk++; if (rx_q[1] !== mem[2]) begin nerr++; $display("FAIL rd_byte1 got %h want %h", rx_q[1], mem[2]); end
    end
    nchk++; if (obs_busy !== 1'b0) begin nerr++; $display("FAIL rd_busy_after_nack got %b want 0", obs_busy); end
    nchk++; if (obs_oe !== 1'b0) begin nerr++; $display("FAIL rd_oe_after_nack got %b want 0", obs_oe); end
    nchk++; if (stb_q.size() != 0) begin nerr++; $display("FAIL rd_stb_count got %0d want 0", stb_q.size()); end
  endtask

  task automatic test_reset_mid();
    logic a;
    logic [7:0] d;
    clear_obs();
    d = 8'($urandom);
    bus_start();
    send_byte({DEV, 1'b0}, -1, a);
    send_byte(8'd3, -1, a);
    for (int i = 0; i < 4; i++) send_bit(d[7-i]);
    nchk++; if (busy !== 1'b1) begin nerr++; $display("FAIL rmid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_50M);
    nchk++; if (sda_oe !== 1'b0) begin nerr++; $display("FAIL rmid_sda_oe got %b want 0", sda_oe); end
    nchk++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got %b want 0", busy); end
    nchk++; if (wr_addr !== 4'd0 || wr_data !== 8'd0) begin nerr++; $display("FAIL rmid_wr got %h/%h want 0/00", wr_addr, wr_data); end
    for (int i = 0; i < 16; i++) begin
      host_addr = 4'(i);
      @(negedge clk_50M);
      nchk++; if (host_rdata !== mem[i]) begin nerr++; $display("FAIL rmid_reg[%0d] got %h want %h", i, host_rdata, mem[i]); end
    end
    m_scl = 1'b1; m_sda = 1'b1;
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_50M);
    clear_obs();
    tx_q.push_back(8'($urandom)); tx_q.push_back(8'($urandom));
    model_wr(4'd9);
    wr_txn(DEV, 8'd9);
    foreach (ack_q[i]) begin
      nchk++; if (ack_q[i] !== 1'b0) begin nerr++; $display("FAIL rmid_post_ack[%0d] got %b want 0", i, ack_q[i]); end
    end
    nchk++;
    if (stb_q.size() != exp_q.size()) begin
      nerr++; $display("FAIL rmid_post_stb_count got %0d want %0d", stb_q.size(), exp_q.size());
    end else foreach (exp_q[i]) begin
      nchk++; if (stb_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rmid_post_stb[%0d] got %h want %h", i, stb_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [3:0] p;
      int n;
      clear_obs();
      p = 4'($urandom);
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 0) begin
        for (int k = 0; k < n; k++) tx_q.push_back(8'($urandom));
        model_wr(p);
        wr_txn(DEV, {4'($urandom), p});
        nchk++;
        if (stb_q.size() != exp_q.size()) begin
          nerr++; $display("FAIL rnd%0d_stb_count got %0d want %0d", it, stb_q.size(), exp_q.size());
        end else foreach (exp_q[i]) begin
          nchk++; if (stb_q[i] !== exp_q[i]) begin nerr++; $display("FAIL rnd%0d_stb[%0d] got %h want %h", it, i, stb_q[i], exp_q[i]); end
        end
      end else begin
        rd_txn({4'($urandom), p}, n);
        nchk++;
        if (rx_q.size() != n) begin
          nerr++; $display("FAIL rnd%0d_rd_count got %0d want %0d", it, rx_q.size(), n);
        end else foreach (rx_q[i]) begin
          nchk++; if (rx_q[i] !== mem[4'(p + 4'(i))]) begin nerr++; $display("FAIL rnd%0d_rd[%0d] got %h want %h", it, i, rx_q[i], mem[4'(p + 4'(i))]); end
        end
        mptr = 4'(p + 4'(n - 1));
      end
      foreach (ack_q[i]) begin
        nchk++; if (ack_q[i] !== 1'b0) begin nerr++; $display("FAIL rnd%0d_ack[%0d] got %b want 0", it, i, ack_q[i]); end
      end
    end
  endtask

  task automatic test_glitch();
    logic a0, a1, a2;
    logic [7:0] d, ex;
    logic smp [$];
    int gi;
    clear_obs();
    d  = 8'($urandom);
    gi = $urandom_range(1, 6);
`ifdef I2C_SPIKE_FILTER_EN
    ex = d;
`else
    for (int i = 0; i < 8; i++) begin
      if (i == gi) smp.push_back(d[7-i]);
      smp.push_back(d[7-i]);
    end
    for (int k = 0; k < 8; k++) ex[7-k] = smp[k];
`endif
    bus_start();
    send_byte({DEV, 1'b0}, -1, a0);
    send_byte(8'd7, -1, a1);
    send_byte(d, gi, a2);
    bus_stop();
    mem[7] = ex;
    nchk++; if (a0 !== 1'b0 || a1 !== 1'b0) begin nerr++; $display("FAIL glitch_hdr_ack got %b%b want 00", a0, a1); end
`ifdef I2C_SPIKE_FILTER_EN
    nchk++; if (a2 !== 1'b0) begin nerr++; $display("FAIL glitch_data_ack got %b want 0", a2); end
`endif
    nchk++;
    if (stb_q.size() != 1) begin
      nerr++; $display("FAIL glitch_stb_count got %0d want 1", stb_q.size());
    end else begin
      nchk++; if (stb_q[0] !== {4'd7, ex}) begin nerr++; $display("FAIL glitch_stb got %h want %h", stb_q[0], {4'd7, ex}); end
    end
    host_addr = 4'd7; @(negedge clk_50M);
    nchk++; if (host_rdata !== mem[7]) begin nerr++; $display("FAIL glitch_reg7 got %h want %h", host_rdata, mem[7]); end
  endtask

  initial begin
    test_reset();
    test_write012();
    test_wrap();
    test_mismatch();
    test_read_rstart();
    test_reset_mid();
    test_random();
    test_glitch();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
